fastmem_refresh_sched: RTL and testbench



---
 rtl/fastmem_refresh_sched_pkg.sv | 30 +++
 rtl/fastmem_refresh_sched_refresh_timer.sv | 59 +++++
 rtl/fastmem_refresh_sched.sv | 130 +++++++++++++
 tb/tb_fastmem_refresh_sched.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/fastmem_refresh_sched_pkg.sv
// -----------------------------------------------------------------------------
// fastmem_refresh_sched_pkg
// Shared definitions for the TF328 FastRAM CAS-before-RAS refresh scheduler.
//   - state encodings of the refresh sequencer
//   - default refresh interval and pending limit, also used by fastmem
//     integration when it instantiates the scheduler
// -----------------------------------------------------------------------------
package fastmem_refresh_sched_pkg;

    // 221 CLKCPU cycles = 15.6 us at 14.18 MHz
    localparam int DEF_REFRESH_INTERVAL = 221;
    localparam int DEF_MAX_PENDING      = 4;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_CBR_CAS  = 3'd1;
    localparam logic [2:0] ST_CBR_RAS  = 3'd2;
    localparam logic [2:0] ST_CBR_HOLD = 3'd3;
    localparam logic [2:0] ST_CBR_TAIL = 3'd4;
    localparam logic [2:0] ST_CBR_PRE  = 3'd5;

    typedef enum logic [2:0] {
        IDLE     = ST_IDLE,
        CBR_CAS  = ST_CBR_CAS,
        CBR_RAS  = ST_CBR_RAS,
        CBR_HOLD = ST_CBR_HOLD,
        CBR_TAIL = ST_CBR_TAIL,
        CBR_PRE  = ST_CBR_PRE
    } ref_state_e;

endpackage

// File: rtl/fastmem_refresh_sched_refresh_timer.sv
// -----------------------------------------------------------------------------
// fastmem_refresh_sched_refresh_timer
// Free-running refresh tick counter plus the saturating count of outstanding
// refreshes and the sticky overrun flag.
// Ports:
//   CLKCPU      in   CPU clock
//   RESET       in   asynchronous active-low reset
//   done        in   a refresh sequence completes this cycle
//   pending     out  outstanding refresh count (registered)
//   pending_nxt out  value pending takes at the next edge
//   overrun     out  sticky: a tick arrived while pending was saturated
// -----------------------------------------------------------------------------
module fastmem_refresh_sched_refresh_timer
    import fastmem_refresh_sched_pkg::*;
#(
    parameter int REFRESH_INTERVAL = DEF_REFRESH_INTERVAL,
    parameter int MAX_PENDING      = DEF_MAX_PENDING
) (
    input  logic       CLKCPU,
    input  logic       RESET,
    input  logic       done,
    output logic [2:0] pending,
    output logic [2:0] pending_nxt,
    output logic       overrun
);

    logic [7:0] tick_cnt;
    logic       tick;
    logic       sat;

    // The wrap cycle itself is the tick.
    assign tick = (tick_cnt == 8'(REFRESH_INTERVAL - 1));
    assign sat  = (pending == 3'(MAX_PENDING));

    // A tick and a completion in the same cycle cancel out.
    always_comb begin
        pending_nxt = pending;
        if (tick && !done && !sat) begin
            pending_nxt = pending + 3'd1;
        end else if (done && !tick) begin
            pending_nxt = pending - 3'd1;
        end
    end

    always_ff @(posedge CLKCPU or negedge RESET) begin
        if (!RESET) begin
            tick_cnt <= 8'd0;
            pending  <= 3'd0;
            overrun  <= 1'b0;
        end else begin
            tick_cnt <= tick ? 8'd0 : tick_cnt + 8'd1;
            pending  <= pending_nxt;
            if (tick && sat) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/fastmem_refresh_sched.sv
// -----------------------------------------------------------------------------
// fastmem_refresh_sched
// CAS-before-RAS refresh scheduler and CPU/refresh arbiter for the TF328
// FastRAM banks. Refreshes are postponed while the CPU strobes AS20 and forced
// once MAX_PENDING are outstanding; a CPU cycle already past idle is never cut.
// Build option: define REFRESH_STAGGER_EN to stagger bank 1 RAS one cycle
// behind bank 0 (adds CBR_TAIL, 5-cycle sequence) to halve peak current.
// Ports:
//   CLKCPU   in   CPU clock, all state on rising edge
//   RESET    in   asynchronous active-low reset
//   AS20     in   CPU address strobe, active-low
//   RAM_SEL  in   FastRAM decode hit, active-low
//   MEM_IDLE in   memory controller idle
//   CPU_GNT  out  controller may start a CPU RAM cycle this clock
//   REF_BUSY out  refresh sequence active
//   REF_RAS  out  refresh RAS per bank, active-low (registered)
//   REF_CAS  out  refresh CAS per byte lane, active-low (registered)
//   PENDING  out  outstanding refresh count
//   OVERRUN  out  sticky: tick arrived at PENDING == MAX_PENDING
// -----------------------------------------------------------------------------
module fastmem_refresh_sched
    import fastmem_refresh_sched_pkg::*;
#(
    parameter int REFRESH_INTERVAL = DEF_REFRESH_INTERVAL,
    parameter int MAX_PENDING      = DEF_MAX_PENDING
) (
    input  logic       CLKCPU,
    input  logic       RESET,
    input  logic       AS20,
    input  logic       RAM_SEL,
    input  logic       MEM_IDLE,
    output logic       CPU_GNT,
    output logic       REF_BUSY,
    output logic [1:0] REF_RAS,
    output logic [3:0] REF_CAS,
    output logic [2:0] PENDING,
    output logic       OVERRUN
);

    ref_state_e state, state_nxt;
    logic       urgent;
    logic       start;
    logic       done;
    logic [2:0] pending_nxt;
    logic [1:0] ras_nxt;
    logic [3:0] cas_nxt;

    fastmem_refresh_sched_refresh_timer #(
        .REFRESH_INTERVAL (REFRESH_INTERVAL),
        .MAX_PENDING      (MAX_PENDING)
    ) u_timer (
        .CLKCPU      (CLKCPU),
        .RESET       (RESET),
        .done        (done),
        .pending     (PENDING),
        .pending_nxt (pending_nxt),
        .overrun     (OVERRUN)
    );

    assign urgent   = (PENDING == 3'(MAX_PENDING));
    assign start    = (state == IDLE) && (PENDING != 3'd0) && MEM_IDLE && (AS20 || urgent);
    assign done     = (state == CBR_PRE);
    assign CPU_GNT  = (state == IDLE) && !start && !urgent;
    assign REF_BUSY = (state != IDLE);

    always_comb begin
        state_nxt = IDLE;
        ras_nxt   = 2'b11;
        cas_nxt   = 4'hF;
        case (state)
            IDLE:     state_nxt = start ? CBR_CAS : IDLE;
            CBR_CAS:  state_nxt = CBR_RAS;
            CBR_RAS:  state_nxt = CBR_HOLD;
`ifdef REFRESH_STAGGER_EN
            CBR_HOLD: state_nxt = CBR_TAIL;
            CBR_TAIL: state_nxt = CBR_PRE;
`else
            CBR_HOLD: state_nxt = CBR_PRE;
`endif
            // Back-to-back catch-up while the CPU stays off the bus.
            CBR_PRE:  state_nxt = ((pending_nxt != 3'd0) && AS20) ? CBR_CAS : IDLE;
            default:  state_nxt = IDLE;
        endcase

        // Strobes are decoded from the state being entered so they come
        // straight out of flops, aligned with the state register.
        case (state_nxt)
            CBR_CAS: cas_nxt = 4'h0;
            CBR_RAS: begin
                cas_nxt = 4'h0;
`ifdef REFRESH_STAGGER_EN
                ras_nxt = 2'b10;
`else
                ras_nxt = 2'b00;
`endif
            end
            CBR_HOLD: begin
                cas_nxt = 4'h0;
                ras_nxt = 2'b00;
            end
`ifdef REFRESH_STAGGER_EN
            CBR_TAIL: begin
                cas_nxt = 4'h0;
                ras_nxt = 2'b01;
            end
`endif
            default: begin
                cas_nxt = 4'hF;
                ras_nxt = 2'b11;
            end
        endcase
    end

    always_ff @(posedge CLKCPU or negedge RESET) begin
        if (!RESET) begin
            state   <= IDLE;
            REF_RAS <= 2'b11;
            REF_CAS <= 4'hF;
        end else begin
            state   <= state_nxt;
            REF_RAS <= ras_nxt;
            REF_CAS <= cas_nxt;
        end
    end

    // A FastRAM CPU strobe is never granted while refresh strobes are active.
    assert property (@(posedge CLKCPU) disable iff (!RESET)
        !(CPU_GNT && REF_BUSY && !AS20 && !RAM_SEL));

endmodule

// File: tb/tb_fastmem_refresh_sched.sv
module tb_fastmem_refresh_sched;
    import fastmem_refresh_sched_pkg::*;

`ifdef REFRESH_STAGGER_EN
    localparam int SEQ_LEN = 5;
`else
    localparam int SEQ_LEN = 4;
`endif

    logic       CLKCPU   = 1'b0;
    logic       RESET    = 1'b0;
    logic       AS20     = 1'b1;
    logic       RAM_SEL  = 1'b1;
    logic       MEM_IDLE = 1'b1;
    logic       CPU_GNT;
    logic       REF_BUSY;
    logic [1:0] REF_RAS;
    logic [3:0] REF_CAS;
    logic [2:0] PENDING;
    logic       OVERRUN;

    int checks   = 0;
    int failures = 0;
    int n        = 0;

    typedef struct {
        logic       as20;
        logic       mem_idle;
        logic       gnt;
        logic       busy;
        logic [1:0] ras;
        logic [3:0] cas;
        logic [2:0] pend;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];

    fastmem_refresh_sched dut (
        .CLKCPU   (CLKCPU),
        .RESET    (RESET),
        .AS20     (AS20),
        .RAM_SEL  (RAM_SEL),
        .MEM_IDLE (MEM_IDLE),
        .CPU_GNT  (CPU_GNT),
        .REF_BUSY (REF_BUSY),
        .REF_RAS  (REF_RAS),
        .REF_CAS  (REF_CAS),
        .PENDING  (PENDING),
        .OVERRUN  (OVERRUN)
    );

    always #5 CLKCPU = ~CLKCPU;

    task automatic chk(input string name, input int act, input int exp);
        checks = checks + 1;
        if (act != exp) begin
            failures = failures + 1;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, n);
        end
    endtask

    // n counts rising edges since reset release; sample 1 ns after the edge
    task automatic step();
        @(posedge CLKCPU);
        #1;
        n = n + 1;
    endtask

    task automatic run_to(input int target, output int busy_seen, output int gnt_lo_seen);
        busy_seen   = 0;
        gnt_lo_seen = 0;
        while (n < target) begin
            step();
            if (REF_BUSY) busy_seen = busy_seen + 1;
            if (!CPU_GNT) gnt_lo_seen = gnt_lo_seen + 1;
        end
    endtask

    function automatic logic [1:0] exp_ras(input int p);
`ifdef REFRESH_STAGGER_EN
        case (p)
            1:       return 2'b10;
            2:       return 2'b00;
            3:       return 2'b01;
            default: return 2'b11;
        endcase
`else
        case (p)
            1, 2:    return 2'b00;
            default: return 2'b11;
        endcase
`endif
    endfunction

    function automatic logic [3:0] exp_cas(input int p);
        return (p < SEQ_LEN - 1) ? 4'h0 : 4'hF;
    endfunction

    initial begin
        int first_cas, ras0_lo, ras1_lo, busy_cnt, gnt_lo;
        int b, g, bc;
        vec_t v, e;

        // burst of three refreshes with AS20 high, then one idle cycle
        for (int s = 0; s < 3; s++) begin
            for (int p = 0; p < SEQ_LEN; p++) begin
                vecs.push_back('{1'b1, 1'b1, 1'b0, 1'b1, exp_ras(p), exp_cas(p), 3'(3 - s)});
            end
        end
        vecs.push_back('{1'b1, 1'b1, 1'b1, 1'b0, 2'b11, 4'hF, 3'd0});

        // reset held
        repeat (3) begin
            @(posedge CLKCPU);
            #1;
        end
        chk("rst_ras", int'(REF_RAS), 3);
        chk("rst_cas", int'(REF_CAS), 15);
        chk("rst_busy", int'(REF_BUSY), 0);
        chk("rst_gnt", int'(CPU_GNT), 1);
        chk("rst_pend", int'(PENDING), 0);
        chk("rst_ovr", int'(OVERRUN), 0);

        // first refresh after release, AS20 high
        RESET = 1'b1;
        n = 0;
        first_cas = -1; ras0_lo = 0; ras1_lo = 0; busy_cnt = 0; gnt_lo = 0;
        while (n < 240) begin
            step();
            if (REF_CAS != 4'hF && first_cas < 0) first_cas = n;
            if (!REF_RAS[0]) ras0_lo = ras0_lo + 1;
            if (!REF_RAS[1]) ras1_lo = ras1_lo + 1;
            if (REF_BUSY) busy_cnt = busy_cnt + 1;
            if (!CPU_GNT) gnt_lo = gnt_lo + 1;
        end
        chk("first_cas_cycle", first_cas, 222);
        chk("ras0_low_cycles", ras0_lo, 2);
        chk("ras1_low_cycles", ras1_lo, 2);
        chk("busy_cycles", busy_cnt, SEQ_LEN);
        chk("gnt_low_cycles", gnt_lo, SEQ_LEN + 1);
        chk("pend_after_first", int'(PENDING), 0);

        // AS20 low across three ticks: refresh postponed
        AS20 = 1'b0;
        run_to(442, b, g);
        chk("pend_tick2", int'(PENDING), 1);
        run_to(663, bc, gnt_lo);
        b = b + bc; g = g + gnt_lo;
        chk("pend_tick3", int'(PENDING), 2);
        run_to(890, bc, gnt_lo);
        b = b + bc; g = g + gnt_lo;
        chk("pend_tick4", int'(PENDING), 3);
        chk("postpone_busy", b, 0);
        chk("postpone_gnt_low", g, 0);

        // AS20 rises: start cycle, then table-driven burst
        AS20 = 1'b1;
        #1;
        chk("burst_start_gnt", int'(CPU_GNT), 0);
        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            AS20 = v.as20;
            MEM_IDLE = v.mem_idle;
            sb.push_back(v);
            step();
            e = sb.pop_front();
            chk($sformatf("vec%0d_gnt", i), int'(CPU_GNT), int'(e.gnt));
            chk($sformatf("vec%0d_busy", i), int'(REF_BUSY), int'(e.busy));
            chk($sformatf("vec%0d_ras", i), int'(REF_RAS), int'(e.ras));
            chk($sformatf("vec%0d_cas", i), int'(REF_CAS), int'(e.cas));
            chk($sformatf("vec%0d_pend", i), int'(PENDING), int'(e.pend));
        end

        // build up to urgent with AS20 low
        AS20 = 1'b0;
        run_to(1760, b, g);
        chk("pre_urgent_busy", b, 0);
        chk("pre_urgent_pend", int'(PENDING), 3);
        MEM_IDLE = 1'b0;
        run_to(1768, bc, g);
        b = b + bc;
        chk("urgent_pend", int'(PENDING), 4);
        chk("urgent_gnt", int'(CPU_GNT), 0);
        run_to(1988, bc, g);
        b = b + bc;
        chk("memidle_low_busy", b, 0);
        chk("ovr_before", int'(OVERRUN), 0);
        step();
        chk("ovr_set", int'(OVERRUN), 1);
        chk("ovr_pend", int'(PENDING), 4);
        run_to(2000, b, g);
        chk("ovr_sticky", int'(OVERRUN), 1);
        chk("ovr_pend_hold", int'(PENDING), 4);
        chk("ovr_no_busy", b, 0);

        // MEM_IDLE returns: refresh despite AS20 low, single sequence
        MEM_IDLE = 1'b1;
        #1;
        chk("urgent_start_gnt", int'(CPU_GNT), 0);
        step();
        chk("urgent_cas", int'(REF_CAS), 0);
        bc = REF_BUSY ? 1 : 0;
        while (REF_BUSY && bc < 20) begin
            step();
            if (REF_BUSY) bc = bc + 1;
        end
        chk("urgent_seq_len", bc, SEQ_LEN);
        chk("urgent_pend_after", int'(PENDING), 3);
        chk("urgent_ovr_after", int'(OVERRUN), 1);
        chk("urgent_gnt_after", int'(CPU_GNT), 1);

        // asynchronous reset in CBR_HOLD
        AS20 = 1'b1;
        step();
        step();
        step();
        chk("hold_ras", int'(REF_RAS), 0);
        chk("hold_busy", int'(REF_BUSY), 1);
        #2;
        RESET = 1'b0;
        #1;
        chk("async_rst_ras", int'(REF_RAS), 3);
        chk("async_rst_cas", int'(REF_CAS), 15);
        chk("async_rst_pend", int'(PENDING), 0);
        chk("async_rst_busy", int'(REF_BUSY), 0);
        chk("async_rst_gnt", int'(CPU_GNT), 1);
        chk("async_rst_ovr", int'(OVERRUN), 0);
        #20;
        RESET = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
